// File: rtl/apb_csr_bank.sv
// APB3 slave register bank: byte-strobed RW registers, read-only and
// write-1-to-clear status registers, per-register access pulses and an interrupt.
module apb_csr_bank #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REG    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REG-1:0]    RO_MASK    = '0,
  parameter logic [NUM_REG-1:0]    W1C_MASK   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          apb_PSEL,
  input  logic [ADDR_WIDTH-1:0]         apb_PADDR,
  input  logic [DATA_WIDTH/8-1:0]       apb_PSTRB,
  input  logic [2:0]                    apb_PPROT,
  input  logic                          apb_PENABLE,
  input  logic                          apb_PWRITE,
  input  logic [DATA_WIDTH-1:0]         apb_PWDATA,
  output logic                          apb_PREADY,
  output logic [DATA_WIDTH-1:0]         apb_PRDATA,
  output logic                          apb_PSLVERROR,
  output logic [NUM_REG*DATA_WIDTH-1:0] o_reg_flat,
  input  logic [NUM_REG*DATA_WIDTH-1:0] i_ro_flat,
  input  logic [NUM_REG*DATA_WIDTH-1:0] i_set_flat,
  output logic [NUM_REG-1:0]            o_wr_pulse,
  output logic [NUM_REG-1:0]            o_rd_pulse,
  output logic                          o_irq
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0]              offs_p0;
  logic [ADDR_WIDTH-1:0]              idx_p0;
  logic [NUM_REG-1:0]                 sel_p0;
  logic [NUM_REG-1:0]                 wr_en_p0;
  logic [NUM_REG-1:0]                 rd_en_p0;
  logic                               commit_p0;
  logic                               addr_err_p0;
  logic                               ro_wr_p0;
  logic                               err_p0;
  logic                               ok_p0;
  logic [DATA_WIDTH-1:0]              wmask_p0;
  logic [DATA_WIDTH-1:0]              clr_p0;
  logic [DATA_WIDTH-1:0]              rdata_p0;
  logic [NUM_REG-1:0][DATA_WIDTH-1:0] reg_q;
  logic [NUM_REG-1:0][DATA_WIDTH-1:0] rd_view;
  logic                               w1c_any;

  logic                               vld_p1;
  logic                               err_p1;
  logic [DATA_WIDTH-1:0]              rdata_p1;
  logic [NUM_REG-1:0]                 wr_pulse_p1;
  logic [NUM_REG-1:0]                 rd_pulse_p1;
  logic                               irq_p1;

  logic                               unused_in;

  // ---- p0: address decode and commit qualification (SETUP with PENABLE) ----
  assign offs_p0     = apb_PADDR - BASE_ADDR;
  assign idx_p0      = {2'b00, offs_p0[ADDR_WIDTH-1:2]};
  assign addr_err_p0 = (apb_PADDR[1:0] != 2'b00) || (apb_PADDR < BASE_ADDR) ||
                       (idx_p0 >= ADDR_WIDTH'(NUM_REG));

  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      sel_p0[i] = (idx_p0 == ADDR_WIDTH'(i));
    end
  end

  assign ro_wr_p0  = apb_PWRITE && |(sel_p0 & RO_MASK);
  assign commit_p0 = (state == SETUP) && apb_PSEL && apb_PENABLE;
  assign err_p0    = addr_err_p0 || ro_wr_p0;
  assign ok_p0     = commit_p0 && !err_p0;
  assign wr_en_p0  = {NUM_REG{ok_p0 && apb_PWRITE}} & sel_p0;
  assign rd_en_p0  = {NUM_REG{ok_p0 && !apb_PWRITE}} & sel_p0;

  always_comb begin
    wmask_p0 = '0;
    for (int b = 0; b < NB; b++) begin
      wmask_p0[b*8 +: 8] = {8{apb_PSTRB[b]}};
    end
  end

  // Strobe-gated write data doubles as the clear mask for sticky registers.
  assign clr_p0 = apb_PWDATA & wmask_p0;

  for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_q[gi]   = '0;
      assign rd_view[gi] = i_ro_flat[gi*DATA_WIDTH +: DATA_WIDTH];
    end else if (W1C_MASK[gi]) begin : g_w1c
      logic [DATA_WIDTH-1:0] q;
      // Set input is sampled every cycle and wins over a simultaneous clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else begin
          q <= (q & ~(wr_en_p0[gi] ? clr_p0 : '0)) |
               i_set_flat[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      assign reg_q[gi]   = q;
      assign rd_view[gi] = q;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (wr_en_p0[gi]) begin
          q <= (q & ~wmask_p0) | clr_p0;
        end
      end
      assign reg_q[gi]   = q;
      assign rd_view[gi] = q;
    end
  end

  always_comb begin
    rdata_p0 = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (sel_p0[i]) rdata_p0 = rdata_p0 | rd_view[i];
    end
  end

  always_comb begin
    w1c_any = 1'b0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (W1C_MASK[i]) w1c_any = w1c_any | (|reg_q[i]);
    end
  end

  // ---- p1: registered bus response, pulses and interrupt ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      rdata_p1    <= '0;
      wr_pulse_p1 <= '0;
      rd_pulse_p1 <= '0;
      irq_p1      <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (apb_PSEL && !apb_PENABLE) state <= SETUP;
        SETUP:   state <= (apb_PSEL && apb_PENABLE) ? ACCESS : IDLE;
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
      vld_p1      <= commit_p0;
      err_p1      <= commit_p0 && err_p0;
      rdata_p1    <= (ok_p0 && !apb_PWRITE) ? rdata_p0 : '0;
      wr_pulse_p1 <= wr_en_p0;
      rd_pulse_p1 <= rd_en_p0;
      irq_p1      <= w1c_any;
    end
  end

  assign apb_PREADY    = vld_p1;
  assign apb_PSLVERROR = err_p1;
  assign apb_PRDATA    = rdata_p1;
  assign o_wr_pulse    = wr_pulse_p1;
  assign o_rd_pulse    = rd_pulse_p1;
  assign o_irq         = irq_p1;
  assign o_reg_flat    = reg_q;

  assign unused_in = ^{apb_PPROT, offs_p0[1:0], i_ro_flat, i_set_flat};

endmodule

// File: tb/tb_apb_csr_bank.sv
// Directed bench for apb_csr_bank: 8 registers at 0x0100, reg 0 read-only,
// reg 4 write-1-to-clear.
module tb_apb_csr_bank;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             apb_PSEL;
  logic [AW-1:0]    apb_PADDR;
  logic [DW/8-1:0]  apb_PSTRB;
  logic [2:0]       apb_PPROT;
  logic             apb_PENABLE;
  logic             apb_PWRITE;
  logic [DW-1:0]    apb_PWDATA;
  logic             apb_PREADY;
  logic [DW-1:0]    apb_PRDATA;
  logic             apb_PSLVERROR;
  logic [NR*DW-1:0] o_reg_flat;
  logic [NR*DW-1:0] i_ro_flat;
  logic [NR*DW-1:0] i_set_flat;
  logic [NR-1:0]    o_wr_pulse;
  logic [NR-1:0]    o_rd_pulse;
  logic             o_irq;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] exp_reg [NR];

  logic          c1_ready;
  logic          c2_ready, c2_err, c2_irq;
  logic [DW-1:0] c2_rdata;
  logic [NR-1:0] c2_wrp, c2_rdp;
  logic          c3_ready, c3_err, c3_irq;
  logic [DW-1:0] c3_rdata;
  logic [NR-1:0] c3_wrp, c3_rdp;

  apb_csr_bank #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REG   (NR),
    .BASE_ADDR (16'h0100),
    .RO_MASK   (8'h01),
    .W1C_MASK  (8'h10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .apb_PSEL     (apb_PSEL),
    .apb_PADDR    (apb_PADDR),
    .apb_PSTRB    (apb_PSTRB),
    .apb_PPROT    (apb_PPROT),
    .apb_PENABLE  (apb_PENABLE),
    .apb_PWRITE   (apb_PWRITE),
    .apb_PWDATA   (apb_PWDATA),
    .apb_PREADY   (apb_PREADY),
    .apb_PRDATA   (apb_PRDATA),
    .apb_PSLVERROR(apb_PSLVERROR),
    .o_reg_flat   (o_reg_flat),
    .i_ro_flat    (i_ro_flat),
    .i_set_flat   (i_set_flat),
    .o_wr_pulse   (o_wr_pulse),
    .o_rd_pulse   (o_rd_pulse),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_r%0d", tag, i), o_reg_flat[i*DW +: DW], exp_reg[i]);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows PREADY, with PSEL released.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [3:0] strb, input logic [DW-1:0] set4);
    apb_PSEL    = 1'b1;
    apb_PENABLE = 1'b0;
    apb_PADDR   = addr;
    apb_PWRITE  = wr;
    apb_PWDATA  = data;
    apb_PSTRB   = strb;
    @(negedge clk);
    c1_ready    = apb_PREADY;
    apb_PENABLE = 1'b1;
    i_set_flat[4*DW +: DW] = set4;
    @(negedge clk);
    i_set_flat[4*DW +: DW] = '0;
    c2_ready = apb_PREADY;
    c2_err   = apb_PSLVERROR;
    c2_rdata = apb_PRDATA;
    c2_wrp   = o_wr_pulse;
    c2_rdp   = o_rd_pulse;
    c2_irq   = o_irq;
    @(negedge clk);
    apb_PSEL    = 1'b0;
    apb_PENABLE = 1'b0;
    c3_ready = apb_PREADY;
    c3_err   = apb_PSLVERROR;
    c3_rdata = apb_PRDATA;
    c3_wrp   = o_wr_pulse;
    c3_rdp   = o_rd_pulse;
    c3_irq   = o_irq;
  endtask

  initial begin
    reset       = 1'b1;
    apb_PSEL    = 1'b0;
    apb_PENABLE = 1'b0;
    apb_PWRITE  = 1'b0;
    apb_PADDR   = '0;
    apb_PSTRB   = '0;
    apb_PPROT   = 3'b010;
    apb_PWDATA  = '0;
    i_ro_flat   = '0;
    i_ro_flat[0 +: DW] = 32'h0000_BEEF;
    i_set_flat  = '0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'b0, apb_PREADY}, 32'h0);
    chk("rst_rdata", apb_PRDATA, 32'h0);
    chk("rst_err", {31'b0, apb_PSLVERROR}, 32'h0);
    chk("rst_wrp", {24'b0, o_wr_pulse}, 32'h0);
    chk("rst_rdp", {24'b0, o_rd_pulse}, 32'h0);
    chk("rst_irq", {31'b0, o_irq}, 32'h0);
    chk("rst_flat", {31'b0, |o_reg_flat}, 32'h0);

    // full-word write and read-back of reg 2
    xfer(1'b1, 16'h0108, 32'hA5A5_1234, 4'hF, '0);
    exp_reg[2] = 32'hA5A5_1234;
    chk("wr2_c1_ready", {31'b0, c1_ready}, 32'h0);
    chk("wr2_c2_ready", {31'b0, c2_ready}, 32'h1);
    chk("wr2_err", {31'b0, c2_err}, 32'h0);
    chk("wr2_wrp", {24'b0, c2_wrp}, 32'h04);
    chk("wr2_wrp_after", {24'b0, c3_wrp}, 32'h0);
    chk("wr2_c3_ready", {31'b0, c3_ready}, 32'h0);
    chk_regs("wr2");
    xfer(1'b0, 16'h0108, '0, 4'h0, '0);
    chk("rd2_c1_ready", {31'b0, c1_ready}, 32'h0);
    chk("rd2_c2_ready", {31'b0, c2_ready}, 32'h1);
    chk("rd2_rdata", c2_rdata, 32'hA5A5_1234);
    chk("rd2_err", {31'b0, c2_err}, 32'h0);
    chk("rd2_rdp", {24'b0, c2_rdp}, 32'h04);
    chk("rd2_wrp", {24'b0, c2_wrp}, 32'h0);
    chk("rd2_rdp_after", {24'b0, c3_rdp}, 32'h0);
    chk("rd2_rdata_after", c3_rdata, 32'h0);

    // byte strobes on reg 1
    xfer(1'b1, 16'h0104, 32'h1111_1111, 4'hF, '0);
    xfer(1'b1, 16'h0104, 32'hFFEE_DDCC, 4'b0101, '0);
    exp_reg[1] = 32'h11EE_11CC;
    chk("strb_wrp", {24'b0, c2_wrp}, 32'h02);
    chk("strb_r1", o_reg_flat[1*DW +: DW], 32'h11EE_11CC);
    xfer(1'b1, 16'h0104, 32'hFFFF_FFFF, 4'h0, '0);
    chk("strb0_wrp", {24'b0, c2_wrp}, 32'h02);
    chk("strb0_err", {31'b0, c2_err}, 32'h0);
    chk_regs("strb0");

    // decode errors and read-only write
    xfer(1'b1, 16'h0120, 32'hDEAD_BEEF, 4'hF, '0);
    chk("oor_wr_ready", {31'b0, c2_ready}, 32'h1);
    chk("oor_wr_err", {31'b0, c2_err}, 32'h1);
    chk("oor_wr_rdata", c2_rdata, 32'h0);
    chk("oor_wr_wrp", {24'b0, c2_wrp}, 32'h0);
    chk("oor_wr_err_after", {31'b0, c3_err}, 32'h0);
    chk_regs("oor_wr");
    xfer(1'b0, 16'h0120, '0, 4'h0, '0);
    chk("oor_rd_err", {31'b0, c2_err}, 32'h1);
    chk("oor_rd_rdata", c2_rdata, 32'h0);
    chk("oor_rd_rdp", {24'b0, c2_rdp}, 32'h0);
    xfer(1'b0, 16'h0102, '0, 4'h0, '0);
    chk("mis_rd_err", {31'b0, c2_err}, 32'h1);
    chk("mis_rd_rdata", c2_rdata, 32'h0);
    chk("mis_rd_rdp", {24'b0, c2_rdp}, 32'h0);
    xfer(1'b1, 16'h0100, 32'h1234_5678, 4'hF, '0);
    chk("ro_wr_err", {31'b0, c2_err}, 32'h1);
    chk("ro_wr_wrp", {24'b0, c2_wrp}, 32'h0);
    chk_regs("ro_wr");
    xfer(1'b0, 16'h00FC, '0, 4'h0, '0);
    chk("low_rd_err", {31'b0, c2_err}, 32'h1);

    // read-only source and last register
    xfer(1'b0, 16'h0100, '0, 4'h0, '0);
    chk("ro_rd_rdata", c2_rdata, 32'h0000_BEEF);
    chk("ro_rd_err", {31'b0, c2_err}, 32'h0);
    chk("ro_rd_rdp", {24'b0, c2_rdp}, 32'h01);
    chk("ro_rd_rdp_after", {24'b0, c3_rdp}, 32'h0);
    xfer(1'b0, 16'h011C, '0, 4'h0, '0);
    chk("last_rd_err", {31'b0, c2_err}, 32'h0);
    chk("last_rd_rdp", {24'b0, c2_rdp}, 32'h80);

    // sticky status register 4
    i_set_flat[4*DW +: DW] = 32'h8;
    @(negedge clk);
    i_set_flat[4*DW +: DW] = '0;
    exp_reg[4] = 32'h8;
    chk("w1c_set_r4", o_reg_flat[4*DW +: DW], 32'h8);
    chk("w1c_irq_lat", {31'b0, o_irq}, 32'h0);
    @(negedge clk);
    chk("w1c_irq", {31'b0, o_irq}, 32'h1);
    xfer(1'b1, 16'h0110, 32'h8, 4'hF, 32'h8);
    chk("w1c_race_err", {31'b0, c2_err}, 32'h0);
    chk("w1c_race_wrp", {24'b0, c2_wrp}, 32'h10);
    chk("w1c_race_irq", {31'b0, c3_irq}, 32'h1);
    chk_regs("w1c_race");
    xfer(1'b1, 16'h0110, 32'h8, 4'h0, '0);
    chk("w1c_nostrb_wrp", {24'b0, c2_wrp}, 32'h10);
    chk_regs("w1c_nostrb");
    xfer(1'b1, 16'h0110, 32'h8, 4'hF, '0);
    exp_reg[4] = 32'h0;
    chk_regs("w1c_clr");
    chk("w1c_clr_irq_c2", {31'b0, c2_irq}, 32'h1);
    chk("w1c_clr_irq_c3", {31'b0, c3_irq}, 32'h0);
    xfer(1'b1, 16'h0110, 32'hFFFF_FFFF, 4'hF, '0);
    chk("w1c_ones_wrp", {24'b0, c2_wrp}, 32'h10);
    chk_regs("w1c_ones");

    // setup abandoned before the access phase
    apb_PSEL   = 1'b1;
    apb_PENABLE = 1'b0;
    apb_PWRITE = 1'b1;
    apb_PADDR  = 16'h010C;
    apb_PWDATA = 32'h55;
    apb_PSTRB  = 4'hF;
    @(negedge clk);
    apb_PSEL = 1'b0;
    chk("abort_ready_a", {31'b0, apb_PREADY}, 32'h0);
    @(negedge clk);
    chk("abort_ready_b", {31'b0, apb_PREADY}, 32'h0);
    chk("abort_wrp_b", {24'b0, o_wr_pulse}, 32'h0);
    @(negedge clk);
    chk("abort_wrp_c", {24'b0, o_wr_pulse}, 32'h0);
    chk_regs("abort");
    xfer(1'b1, 16'h010C, 32'h33, 4'hF, '0);
    exp_reg[3] = 32'h33;
    chk("post_abort_ready", {31'b0, c2_ready}, 32'h1);
    chk("post_abort_wrp", {24'b0, c2_wrp}, 32'h08);
    chk_regs("post_abort");

    // reset in the first access cycle of a write
    i_set_flat[4*DW +: DW] = 32'h1;
    @(negedge clk);
    i_set_flat[4*DW +: DW] = '0;
    @(negedge clk);
    chk("pre_rst_irq", {31'b0, o_irq}, 32'h1);
    apb_PSEL    = 1'b1;
    apb_PENABLE = 1'b0;
    apb_PWRITE  = 1'b1;
    apb_PADDR   = 16'h0114;
    apb_PWDATA  = 32'h77;
    apb_PSTRB   = 4'hF;
    @(negedge clk);
    apb_PENABLE = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    apb_PSEL    = 1'b0;
    apb_PENABLE = 1'b0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    chk("mid_rst_ready", {31'b0, apb_PREADY}, 32'h0);
    chk("mid_rst_err", {31'b0, apb_PSLVERROR}, 32'h0);
    chk("mid_rst_rdata", apb_PRDATA, 32'h0);
    chk("mid_rst_wrp", {24'b0, o_wr_pulse}, 32'h0);
    chk("mid_rst_irq", {31'b0, o_irq}, 32'h0);
    chk_regs("mid_rst");
    xfer(1'b1, 16'h0114, 32'h77, 4'hF, '0);
    exp_reg[5] = 32'h77;
    chk("after_rst_ready", {31'b0, c2_ready}, 32'h1);
    chk("after_rst_wrp", {24'b0, c2_wrp}, 32'h20);
    chk_regs("after_rst");

    // set pulse on the first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_set_flat[4*DW +: DW] = 32'h2;
    @(negedge clk);
    i_set_flat[4*DW +: DW] = '0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    exp_reg[4] = 32'h2;
    chk_regs("rel_set");
    xfer(1'b0, 16'h0110, '0, 4'h0, '0);
    chk("rel_set_rdata", c2_rdata, 32'h2);
    chk("rel_set_rdp", {24'b0, c2_rdp}, 32'h10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_csr_bank.md
# apb_csr_bank

Parametrised APB3 slave register bank. It is the next-generation control/status block between the RISC-V APB bus and the camera datapath. It adds the following over the fixed-map register file:
- configurable register count and base address
- byte-strobe writes
- per-register read-only and write-1-to-clear (sticky status) modes
- per-register access pulses
- decode-error signalling on PSLVERROR
- an aggregated interrupt output

## Interface
- ADDR_WIDTH, 16, APB address width
- DATA_WIDTH, 32, data width; must be a multiple of 8
- NUM_REG, 32, number of 32-bit word registers, 1..256
- BASE_ADDR, 0, byte address of register 0; word aligned
- RO_MASK, 0, NUM_REG bits; bit i=1 makes reg i read-only, sourced from i_ro_flat
- W1C_MASK, 0, NUM_REG bits; bit i=1 makes reg i a sticky status register, set by i_set_flat and cleared by writing 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- apb_PSEL  in  1  slave select
- apb_PADDR  in  ADDR_WIDTH  byte address
- apb_PSTRB  in  DATA_WIDTH/8  write byte strobes
- apb_PPROT  in  3  ignored
- apb_PENABLE  in  1  access phase
- apb_PWRITE  in  1  1=write
- apb_PWDATA  in  DATA_WIDTH  write data
- apb_PREADY  out  1  transfer complete
- apb_PRDATA  out  DATA_WIDTH  read data, valid with PREADY
- apb_PSLVERROR  out  1  transfer error, valid with PREADY
- o_reg_flat  out  NUM_REG*DATA_WIDTH  register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- i_ro_flat  in  NUM_REG*DATA_WIDTH  read values for RO registers
- i_set_flat  in  NUM_REG*DATA_WIDTH  per-bit set strobes for W1C registers
- o_wr_pulse  out  NUM_REG  one-cycle pulse on each successful write to reg i
- o_rd_pulse  out  NUM_REG  one-cycle pulse on each successful read of reg i
- o_irq  out  1  OR of all bits of all W1C registers

## Operation
- Bus FSM states are IDLE, SETUP and ACCESS.
  - IDLE goes to SETUP on PSEL & !PENABLE.
  - SETUP goes to ACCESS on PSEL & PENABLE, and otherwise returns to IDLE as an abort with no side effects.
  - ACCESS goes to IDLE unconditionally.
- Commit edge: the edge on which the FSM moves SETUP to ACCESS. All of the following happen on this edge:
  - the register write
  - the PRDATA capture
  - the error decision
  - the pulse generation
- Decode:
  - idx = (PADDR - BASE_ADDR) >> 2.
  - An error is raised if PADDR[1:0] != 0, PADDR < BASE_ADDR, or idx >= NUM_REG.
  - A write to an RO register is also an error.
- Plain RW write: byte b of reg idx takes PWDATA byte b iff PSTRB[b]=1.
  - PSTRB=0 leaves the data unchanged, but still counts as a successful write and raises o_wr_pulse.
- W1C register, per bit, each cycle: next = (cur & ~clr) | set.
  - clr is the PWDATA bit gated by its strobe on the commit edge.
  - set is the i_set_flat bit.
  - Set dominates when set and clear coincide.
  - W1C registers are not writable with 1s in any other way.
- Reads:
  - RO regs return i_ro_flat sampled at the commit edge.
  - All other regs return the stored value.
  - An errored read returns 0.
- Errored transfers:
  - no register change
  - no pulse
  - PSLVERROR=1
- For RO/W1C regs, o_reg_flat carries the stored value: 0 for RO, the sticky value for W1C.

## Timing
- Every output resets to 0: FSM IDLE, all registers, PRDATA, PREADY, PSLVERROR, pulses, o_irq.
- Reset asserted mid-transfer forces the reset state on the next edge. The transfer is lost and no pulse is generated.
- Cycle sequence:
  - Cycle 0: setup.
  - Cycle 1: first PENABLE cycle; PREADY=0 (one fixed wait state).
  - Cycle 2: PREADY=1, with PRDATA, PSLVERROR, o_wr_pulse/o_rd_pulse and the new o_reg_flat all valid.
- A transfer therefore takes 3 cycles, and a back-to-back setup may start in the cycle after PREADY.
- PREADY, PRDATA and PSLVERROR are registered. PSLVERROR and PRDATA are held 0 whenever PREADY=0.
- o_irq is registered and follows W1C state with 1-cycle latency.
- i_set_flat pulses of one cycle are never lost, including during reset release (first edge after deassertion) and during a W1C clear.
- PSEL dropping in ACCESS has no effect: the transfer is already committed.

## Test plan
- Reset write/read:
  - Stimulus: reset, then write 0xA5A5_1234 with PSTRB=0xF to BASE_ADDR+0x8, then read it back.
  - Required response: PRDATA=0xA5A5_1234 and PSLVERROR=0; o_wr_pulse[2] high for exactly one cycle, coincident with PREADY; PREADY on the third cycle of each transfer.
- Byte strobes:
  - Stimulus: reg 1 holds 0x1111_1111; write 0xFFEE_DDCC with PSTRB=0b0101.
  - Required response: reg 1 = 0x11EE_11CC.
- Errors:
  - Stimulus: access address BASE_ADDR+NUM_REG*4, address BASE_ADDR+0x2, and a write to an RO register.
  - Required response: each completes with PSLVERROR=1 and PRDATA=0, with no register change and no pulse.
- W1C:
  - Stimulus: pulse i_set_flat bit 3 of W1C reg 4; then write 0x8 to reg 4 while simultaneously pulsing set bit 3.
  - Required response: o_irq=1 after the first pulse; the bit is still 1 after the write; a second write of 0x8 without set clears it and o_irq returns to 0.
- RO read:
  - Stimulus: i_ro_flat reg 0 = 0x0000_BEEF; read reg 0.
  - Required response: PRDATA=0x0000_BEEF and o_rd_pulse[0] for one cycle.
- Abort and reset:
  - Stimulus: PSEL deasserted in the setup cycle; separately, reset asserted in cycle 1 of a write.
  - Required response: no write and no pulse; after reset all outputs are 0 and the FSM accepts a new transfer immediately.
